// File: rtl/led_display_capture_if.sv
// Pin-side and readback signals of the LED display capture block.
// frame_cnt/err_cnt exist only when DISPLAY_CAPTURE_STATS_EN is defined.
interface led_display_capture_if #(
  parameter int NUM = 4
);
  logic [7:0]       led_display_seg;
  logic [NUM-1:0]   led_display_sel;
  logic [NUM*8-1:0] led_out;
  logic [NUM-1:0]   led_valid;
  logic             led_update;
  logic             scan_err;
`ifdef DISPLAY_CAPTURE_STATS_EN
  logic [15:0]      frame_cnt;
  logic [15:0]      err_cnt;

  modport master (
    output led_display_seg, led_display_sel,
    input  led_out, led_valid, led_update, scan_err, frame_cnt, err_cnt
  );
  modport slave (
    input  led_display_seg, led_display_sel,
    output led_out, led_valid, led_update, scan_err, frame_cnt, err_cnt
  );
`else
  modport master (
    output led_display_seg, led_display_sel,
    input  led_out, led_valid, led_update, scan_err
  );
  modport slave (
    input  led_display_seg, led_display_sel,
    output led_out, led_valid, led_update, scan_err
  );
`endif
endinterface

// File: rtl/led_display_capture.sv
// Reconstructs per-digit segment bytes from scanned 7-seg pins (debounced, with timeout).
// Optional frame/error counters are built only with `define DISPLAY_CAPTURE_STATS_EN.
module led_display_capture #(
  parameter int   NUM            = 4,
  parameter logic VALID_SIGNAL   = 1'b0,
  parameter int   STABLE_CYCLES  = 16,
  parameter int   TIMEOUT_CYCLES = 2000000
) (
  input logic                  clk,
  input logic                  rstn,
  led_display_capture_if.slave bus
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [7:0]     SEG_IDLE = {8{~VALID_SIGNAL}};
  localparam logic [NUM-1:0] SEL_IDLE = {NUM{~VALID_SIGNAL}};

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

  logic [7:0]     seg_s1_q, seg_s2_q;
  logic [NUM-1:0] sel_s1_q, sel_s2_q;
  logic [7:0]     seg_n;
  logic [NUM-1:0] sel_n;
  logic           sel_one, sel_multi;
  logic [KW-1:0]  sel_k;
  logic           scan_err_q, scan_err_d;

  state_e         state_q, state_d;
  logic [SW-1:0]  stable_q, stable_d;
  logic [7:0]     rec_seg_q, rec_seg_d;
  logic [NUM-1:0] rec_sel_q, rec_sel_d;
  logic [KW-1:0]  rec_k_q, rec_k_d;
  logic           changed, cap;
  logic [NUM-1:0] cap_vec;

  logic [NUM-1:0][7:0] led_byte;
  logic [NUM-1:0]      vld_vec, chg_vec;
  logic                led_update_q;

  // Two-flop synchroniser; idles at the inactive pin level so reset looks like blanking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_s1_q <= SEG_IDLE;
      seg_s2_q <= SEG_IDLE;
      sel_s1_q <= SEL_IDLE;
      sel_s2_q <= SEL_IDLE;
    end else begin
      seg_s1_q <= bus.led_display_seg;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= bus.led_display_sel;
      sel_s2_q <= sel_s1_q;
    end
  end

  assign seg_n     = seg_s2_q ^ SEG_IDLE;
  assign sel_n     = sel_s2_q ^ SEL_IDLE;
  assign sel_one   = (sel_n != '0) && ((sel_n & (sel_n - NUM'(1))) == '0);
  assign sel_multi = (sel_n != '0) && !sel_one;
  assign scan_err_d = sel_multi;

  always_comb begin
    sel_k = '0;
    for (int i = 0; i < NUM; i++)
      if (sel_n[i]) sel_k = KW'(i);
  end

  assign changed = (seg_n != rec_seg_q) || (sel_n != rec_sel_q);

  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    rec_seg_d = rec_seg_q;
    rec_sel_d = rec_sel_q;
    rec_k_d   = rec_k_q;
    cap       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_one) begin
          state_d   = SETTLE;
          stable_d  = SW'(1);
          rec_seg_d = seg_n;
          rec_sel_d = sel_n;
          rec_k_d   = sel_k;
        end
      end
      SETTLE, HOLD: begin
        if (changed) begin
          if (sel_one) begin
            state_d   = SETTLE;
            stable_d  = SW'(1);
            rec_seg_d = seg_n;
            rec_sel_d = sel_n;
            rec_k_d   = sel_k;
          end else begin
            state_d  = IDLE;
            stable_d = '0;
          end
        end else if (state_q == SETTLE) begin
          // Counter saturates at the window length; it never wraps.
          if (stable_q >= SW'(STABLE_CYCLES - 1)) begin
            stable_d = SW'(STABLE_CYCLES);
            state_d  = CAPTURE;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
      end
      CAPTURE: begin
        cap     = 1'b1;
        state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      stable_q   <= '0;
      rec_seg_q  <= '0;
      rec_sel_q  <= '0;
      rec_k_q    <= '0;
      scan_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stable_q   <= stable_d;
      rec_seg_q  <= rec_seg_d;
      rec_sel_q  <= rec_sel_d;
      rec_k_q    <= rec_k_d;
      scan_err_q <= scan_err_d;
    end
  end

  always_comb begin
    cap_vec = '0;
    for (int i = 0; i < NUM; i++)
      cap_vec[i] = cap && (rec_k_q == KW'(i));
  end

  // Per-digit byte, valid flag and timeout counter; a capture beats a same-cycle timeout.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          vld_q, vld_d;

    always_comb begin
      tcnt_d = tcnt_q;
      byte_d = byte_q;
      vld_d  = vld_q;
      if (cap_vec[i]) begin
        tcnt_d = '0;
        byte_d = rec_seg_q;
        vld_d  = 1'b1;
      end else if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
        tcnt_d = tcnt_q + TW'(1);
        if (tcnt_d == TW'(TIMEOUT_CYCLES)) begin
          byte_d = '0;
          vld_d  = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        tcnt_q <= '0;
        byte_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        tcnt_q <= tcnt_d;
        byte_q <= byte_d;
        vld_q  <= vld_d;
      end
    end

    assign led_byte[i] = byte_q;
    assign vld_vec[i]  = vld_q;
    assign chg_vec[i]  = (byte_d != byte_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) led_update_q <= 1'b0;
    else       led_update_q <= |chg_vec;
  end

  assign bus.led_out    = led_byte;
  assign bus.led_valid  = vld_vec;
  assign bus.led_update = led_update_q;
  assign bus.scan_err   = scan_err_q;

`ifdef DISPLAY_CAPTURE_STATS_EN
  logic [NUM-1:0] seen_q, seen_d;
  logic [15:0]    frame_q, frame_d, err_q, err_d;

  // A frame closes on a digit-0 capture once every digit has been seen since the last close.
  always_comb begin
    seen_d  = seen_q;
    frame_d = frame_q;
    err_d   = err_q;
    if (cap) begin
      seen_d = seen_q | cap_vec;
      if ((rec_k_q == '0) && (&seen_d)) begin
        seen_d = '0;
        if (frame_q != 16'hFFFF) frame_d = frame_q + 16'd1;
      end
    end
    if (scan_err_d && !scan_err_q && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen_q  <= '0;
      frame_q <= '0;
      err_q   <= '0;
    end else begin
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign bus.frame_cnt = frame_q;
  assign bus.err_cnt   = err_q;
`endif
endmodule

// File: tb/tb_led_display_capture.sv
// Bench for led_display_capture: directed scans plus random pin segments, checked every cycle
// against an event-level model (capture at change+STABLE+3, timeout at capture+TIMEOUT).
module tb_led_display_capture;
  localparam int   NUM  = 4;
  localparam logic VS   = 1'b0;
  localparam int   ST   = 16;
  localparam int   TO   = 5000;
  localparam int   HMAX = 1 << 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  led_display_capture_if #(.NUM(NUM)) bus ();

  led_display_capture #(
    .NUM(NUM), .VALID_SIGNAL(VS), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [NUM-1:0][7:0] exp_out;
  logic [NUM-1:0]      exp_val;
  logic                exp_upd, exp_err;
  int                  last[NUM];
  bit                  cap_en[HMAX];
  int                  cap_dig[HMAX];
  logic [7:0]          cap_byte[HMAX];
  bit                  err_exp[HMAX];
  int                  upd_seen, err_seen, last_upd, t_fall2;
  logic                prev_v2 = 1'b0;
  logic [7:0]          cur_seg;
  logic [NUM-1:0]      cur_sel;
`ifdef DISPLAY_CAPTURE_STATS_EN
  int                  exp_frames, exp_errs;
  logic [NUM-1:0]      seen;
  logic                prev_err;
`endif

  function automatic logic [NUM-1:0] rsel(int d);
    return (NUM'(1) << d) ^ {NUM{~VS}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    exp_out = '0;
    exp_val = '0;
    for (int c = cyc + 1; c < cyc + 1200 && c < HMAX; c++) begin
      cap_en[c]  = 1'b0;
      err_exp[c] = 1'b0;
    end
`ifdef DISPLAY_CAPTURE_STATS_EN
    exp_frames = 0; exp_errs = 0; seen = '0; prev_err = 1'b0;
`endif
  endtask

  // One clock: advance the model to this edge, then compare every output.
  task automatic step();
    int cd;
    @(posedge clk);
    cyc++;
    exp_upd = 1'b0;
    exp_err = 1'b0;
    cd = -1;
    if (rstn) begin
      exp_err = err_exp[cyc];
      if (cap_en[cyc]) begin
        cd = cap_dig[cyc];
        if (exp_out[cd] != cap_byte[cyc]) exp_upd = 1'b1;
        exp_out[cd] = cap_byte[cyc];
        exp_val[cd] = 1'b1;
        last[cd]    = cyc;
`ifdef DISPLAY_CAPTURE_STATS_EN
        seen[cd] = 1'b1;
        if (cd == 0 && (&seen)) begin exp_frames++; seen = '0; end
`endif
      end
      for (int i = 0; i < NUM; i++)
        if (i != cd && exp_val[i] && (cyc - last[i] == TO)) begin
          if (exp_out[i] != 8'h00) exp_upd = 1'b1;
          exp_out[i] = 8'h00;
          exp_val[i] = 1'b0;
        end
`ifdef DISPLAY_CAPTURE_STATS_EN
      if (exp_err && !prev_err) exp_errs++;
      prev_err = exp_err;
`endif
    end
    #1;
    if (bus.led_update) begin upd_seen++; last_upd = cyc; end
    if (bus.scan_err) err_seen++;
    if (prev_v2 && !bus.led_valid[2]) t_fall2 = cyc;
    prev_v2 = bus.led_valid[2];
    if (errors < 50) begin
      chk("led_out",    64'(bus.led_out),    64'(exp_out));
      chk("led_valid",  64'(bus.led_valid),  64'(exp_val));
      chk("led_update", 64'(bus.led_update), 64'(exp_upd));
      chk("scan_err",   64'(bus.scan_err),   64'(exp_err));
`ifdef DISPLAY_CAPTURE_STATS_EN
      chk("frame_cnt",  64'(bus.frame_cnt),  64'(exp_frames));
      chk("err_cnt",    64'(bus.err_cnt),    64'(exp_errs));
`endif
    end
  endtask

  // Pins just changed (or reset just released) after edge cyc; schedule what the pattern causes.
  task automatic hold(input logic [7:0] seg_raw, input logic [NUM-1:0] sel_raw, input int dur);
    logic [NUM-1:0] ln;
    int k;
    ln = sel_raw ^ {NUM{~VS}};
    if ($countones(ln) == 1 && dur >= ST) begin
      k = 0;
      for (int i = 0; i < NUM; i++) if (ln[i]) k = i;
      cap_en[cyc + ST + 3]   = 1'b1;
      cap_dig[cyc + ST + 3]  = k;
      cap_byte[cyc + ST + 3] = seg_raw ^ {8{~VS}};
    end
    if ($countones(ln) > 1)
      for (int c = cyc + 3; c < cyc + 3 + dur; c++) err_exp[c] = 1'b1;
    repeat (dur) step();
  endtask

  task automatic drive(input logic [7:0] seg_raw, input logic [NUM-1:0] sel_raw, input int dur);
    @(negedge clk);
    bus.led_display_seg = seg_raw;
    bus.led_display_sel = sel_raw;
    cur_seg = seg_raw;
    cur_sel = sel_raw;
    hold(seg_raw, sel_raw, dur);
  endtask

  initial begin
    logic [7:0]     t1_seg[NUM];
    logic [7:0]     t6_seg[NUM];
    logic [7:0]     rs;
    logic [NUM-1:0] rl, ln;
    int             t_rel, dur, r;

    t1_seg = '{8'hFF, 8'hAA, 8'h55, 8'h00};
    t6_seg = '{8'h81, 8'h12, 8'hE7, 8'h3C};
    bus.led_display_seg = {8{~VS}};
    bus.led_display_sel = {NUM{~VS}};
    cur_seg = {8{~VS}};
    cur_sel = {NUM{~VS}};
    upd_seen = 0; err_seen = 0; last_upd = 0; t_fall2 = 0;
    for (int i = 0; i < NUM; i++) last[i] = 0;
    model_reset();

    // Reset state
    repeat (3) step();
    chk("rst_out", 64'(bus.led_out), 64'd0);
    chk("rst_valid", 64'(bus.led_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: ideal scan; active-low pins, so raw FF/AA/55/00 become 00/55/AA/FF on digits 0..3.
    // Digit 0 normalises to 00, equal to its reset value, so only three bytes change.
    upd_seen = 0;
    for (int d = 0; d < NUM; d++) drive(t1_seg[d], rsel(d), 1000);
    chk("t1_out", 64'(bus.led_out), 64'h0000_0000_FFAA_5500);
    chk("t1_valid", 64'(bus.led_valid), 64'hF);
    chk("t1_updates", 64'(upd_seen), 64'd3);

    // 2: 5-cycle seg glitch on digit 1 must be ignored
    drive(8'hAA, rsel(1), 200);
    upd_seen = 0;
    drive(8'h0F, rsel(1), 5);
    drive(8'hAA, rsel(1), 200);
    chk("t2_byte1", 64'(bus.led_out[15:8]), 64'h55);
    chk("t2_updates", 64'(upd_seen), 64'd0);

    // 3: multi-hot select raises scan_err for exactly the pattern's duration
    upd_seen = 0; err_seen = 0;
    drive(8'h00, 4'b1100, 100);
    drive(8'hFF, {NUM{~VS}}, 50);
    chk("t3_err_cycles", 64'(err_seen), 64'd100);
    chk("t3_updates", 64'(upd_seen), 64'd0);

    // 4: stop scanning digit 2; it must time out exactly TO cycles after its last capture
    upd_seen = 0; t_fall2 = 0;
    for (int f = 0; f < 2; f++) begin
      drive(t1_seg[0], rsel(0), 1000);
      drive(t1_seg[1], rsel(1), 1000);
      drive(t1_seg[3], rsel(3), 1000);
    end
    chk("t4_valid", 64'(bus.led_valid), 64'b1011);
    chk("t4_byte2", 64'(bus.led_out[23:16]), 64'h00);
    chk("t4_fall_delay", 64'(t_fall2 - last[2]), 64'(TO));
    chk("t4_updates", 64'(upd_seen), 64'd1);

    // 5: reset in the middle of a settle window
    drive(8'h3C, rsel(0), 8);
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_out", 64'(bus.led_out), 64'd0);
    chk("t5_rst_valid", 64'(bus.led_valid), 64'd0);
    chk("t5_rst_update", 64'(bus.led_update), 64'd0);
    chk("t5_rst_err", 64'(bus.scan_err), 64'd0);
    repeat (3) step();
    @(negedge clk);
    rstn = 1'b1;
    t_rel = cyc;
    upd_seen = 0;
    hold(8'h3C, rsel(0), 40);
    chk("t5_latency", 64'(last_upd - t_rel), 64'(ST + 3));
    chk("t5_updates", 64'(upd_seen), 64'd1);

    // 6: identical repeated frames produce no further updates
    for (int f = 0; f < 4; f++) begin
      if (f == 1) upd_seen = 0;
      for (int d = 0; d < NUM; d++) drive(t6_seg[d], rsel(d), 40);
    end
    chk("t6_updates", 64'(upd_seen), 64'd0);
    chk("t6_valid", 64'(bus.led_valid), 64'hF);

    // 7: random pin segments; ONE patterns are either clearly short or clearly long
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rl = rsel($urandom_range(0, NUM - 1));
      end else if (r < 8) begin
        rl = {NUM{~VS}};
      end else begin
        ln = NUM'($urandom);
        while ($countones(ln) < 2) ln = NUM'($urandom);
        rl = ln ^ {NUM{~VS}};
      end
      rs  = 8'($urandom);
      dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : $urandom_range(20, 60);
      if (rs == cur_seg && rl == cur_sel) rs = rs ^ 8'h01;
      drive(rs, rl, dur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
